// File: rtl/fs_ds_inst_queue_if.sv
// IF->ID handshake bundle for the decoupling instruction queue.
// master: the surrounding pipeline (fetch side and decode side); slave: the queue.
interface fs_ds_inst_queue_if #(
  parameter int BUS_WD = 72
);
  logic              fs_to_q_valid;
  logic              q_allowin;
  logic [BUS_WD-1:0] fs_to_q_bus;
  logic              q_to_ds_valid;
  logic              ds_allowin;
  logic [BUS_WD-1:0] q_to_ds_bus;

  modport master (
    output fs_to_q_valid,
    output fs_to_q_bus,
    output ds_allowin,
    input  q_allowin,
    input  q_to_ds_valid,
    input  q_to_ds_bus
  );

  modport slave (
    input  fs_to_q_valid,
    input  fs_to_q_bus,
    input  ds_allowin,
    output q_allowin,
    output q_to_ds_valid,
    output q_to_ds_bus
  );
endinterface

// File: rtl/fs_ds_inst_queue.sv
// Instruction queue between IF and ID: DEPTH-entry FIFO with flush and a
// fetch stop after any entry flagged as an exception.
module fs_ds_inst_queue #(
  parameter int BUS_WD = 72,
  parameter int DEPTH  = 4,
  parameter int EX_BIT = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  fs_ds_inst_queue_if.slave        qif,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BUS_WD-1:0] mem_q [DEPTH];
  logic [BUS_WD-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ex_hold_q, ex_hold_d;

  logic allowin_s;
  logic valid_s;
  logic push_s;
  logic pop_s;

  // Handshake terms; allowin looks only at registered state so a full queue
  // never takes a push in the same cycle as a pop.
  always_comb begin
    allowin_s = (count_q != CNT_W'(DEPTH)) & ~ex_hold_q;
    valid_s   = (count_q != CNT_W'(0)) & ~flush;
    push_s    = qif.fs_to_q_valid & allowin_s & ~flush;
    pop_s     = valid_s & qif.ds_allowin;
  end

  assign qif.q_allowin     = allowin_s;
  assign qif.q_to_ds_valid = valid_s;
  assign qif.q_to_ds_bus   = mem_q[rd_ptr_q];
  assign q_count           = count_q;

  // Next-state for storage, pointers, occupancy and the exception hold.
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ex_hold_d = ex_hold_q;
    if (flush) begin
      // Stored data is left in place; only the bookkeeping is discarded.
      rd_ptr_d  = {PTR_W{1'b0}};
      wr_ptr_d  = {PTR_W{1'b0}};
      count_d   = {CNT_W{1'b0}};
      ex_hold_d = 1'b0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = qif.fs_to_q_bus;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
      ex_hold_d = ex_hold_q | (push_s & qif.fs_to_q_bus[EX_BIT]);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {BUS_WD{1'b0}};
      end
      rd_ptr_q  <= {PTR_W{1'b0}};
      wr_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      ex_hold_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ex_hold_q <= ex_hold_d;
    end
  end

endmodule

// File: tb/tb_fs_ds_inst_queue.sv
// Directed vector table plus multi-cycle sequences for fs_ds_inst_queue.
module tb_fs_ds_inst_queue;
  localparam int BUS_WD = 72;
  localparam int DEPTH  = 4;
  localparam int NVEC   = 25;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic [2:0] q_count;

  int errors = 0;
  int checks = 0;

  fs_ds_inst_queue_if #(.BUS_WD(BUS_WD)) qif ();

  fs_ds_inst_queue #(.BUS_WD(BUS_WD), .DEPTH(DEPTH), .EX_BIT(64)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (flush),
    .qif     (qif),
    .q_count (q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        ex;
    logic        da;
    logic        fl;
    logic        e_allow;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_ex;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vt [NVEC];

  // Bundle layout {esubcode[0], ecode[5:0], ex, inst, pc}; inst is ~pc so the
  // upper word is also checked.
  function automatic logic [BUS_WD-1:0] mk(input logic [31:0] pc, input logic ex);
    return {7'h00, ex, ~pc, pc};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [31:0] pc, input logic ex,
                               input logic da, input logic fl, input logic e_allow,
                               input logic e_valid, input logic [31:0] e_pc,
                               input logic e_ex, input logic [2:0] e_cnt);
    vec_t r;
    r.v = v; r.pc = pc; r.ex = ex; r.da = da; r.fl = fl;
    r.e_allow = e_allow; r.e_valid = e_valid; r.e_pc = e_pc; r.e_ex = e_ex; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [BUS_WD-1:0] act, input logic [BUS_WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic ex,
                       input logic da, input logic fl);
    qif.fs_to_q_valid = v;
    qif.fs_to_q_bus   = mk(pc, ex);
    qif.ds_allowin    = da;
    flush             = fl;
  endtask

  logic [BUS_WD-1:0] mq [$];

  initial begin
    // Test 1: basic order
    vt[0]  = mkv(1'b1, 32'h1c000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
    vt[1]  = mkv(1'b1, 32'h1c000004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000000, 1'b0, 3'd1);
    vt[2]  = mkv(1'b1, 32'h1c000008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000000, 1'b0, 3'd2);
    vt[3]  = mkv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1c000000, 1'b0, 3'd3);
    vt[4]  = mkv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1c000004, 1'b0, 3'd2);
    vt[5]  = mkv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1c000008, 1'b0, 3'd1);
    vt[6]  = mkv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
    // Test 2: full, held-off fifth push, pop+push while full
    vt[7]  = mkv(1'b1, 32'h1c000020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
    vt[8]  = mkv(1'b1, 32'h1c000024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000020, 1'b0, 3'd1);
    vt[9]  = mkv(1'b1, 32'h1c000028, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000020, 1'b0, 3'd2);
    vt[10] = mkv(1'b1, 32'h1c00002c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000020, 1'b0, 3'd3);
    vt[11] = mkv(1'b1, 32'h1c000030, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1c000020, 1'b0, 3'd4);
    vt[12] = mkv(1'b1, 32'h1c000030, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000020, 1'b0, 3'd4);
    vt[13] = mkv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1c000024, 1'b0, 3'd3);
    // Test 3: flush with 3 entries and a concurrent push
    vt[14] = mkv(1'b1, 32'h1c000040, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 3'd3);
    vt[15] = mkv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
    vt[16] = mkv(1'b1, 32'h1c000100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
    vt[17] = mkv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1c000100, 1'b0, 3'd1);
    vt[18] = mkv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
    // Test 4: exception hold
    vt[19] = mkv(1'b1, 32'h1c000010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);
    vt[20] = mkv(1'b1, 32'h1c000014, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1c000010, 1'b1, 3'd1);
    vt[21] = mkv(1'b1, 32'h1c000014, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000010, 1'b1, 3'd1);
    vt[22] = mkv(1'b1, 32'h1c000014, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 3'd0);
    vt[23] = mkv(1'b1, 32'h1c000014, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 3'd0);
    vt[24] = mkv(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 3'd0);

    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_valid", BUS_WD'(qif.q_to_ds_valid), BUS_WD'(1'b0));
    chk("rst_count", BUS_WD'(q_count), BUS_WD'(3'd0));
    chk("rst_bus",   qif.q_to_ds_bus, {BUS_WD{1'b0}});
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_allowin", BUS_WD'(qif.q_allowin), BUS_WD'(1'b1));

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].pc, vt[i].ex, vt[i].da, vt[i].fl);
      #1;
      chk($sformatf("v%0d_allowin", i), BUS_WD'(qif.q_allowin), BUS_WD'(vt[i].e_allow));
      chk($sformatf("v%0d_valid", i), BUS_WD'(qif.q_to_ds_valid), BUS_WD'(vt[i].e_valid));
      chk($sformatf("v%0d_count", i), BUS_WD'(q_count), BUS_WD'(vt[i].e_cnt));
      if (vt[i].e_valid)
        chk($sformatf("v%0d_bus", i), qif.q_to_ds_bus, mk(vt[i].e_pc, vt[i].e_ex));
    end

    // Test 5: random push/pop against a reference queue (queue is empty here)
    for (int i = 0; i < 1000; i++) begin
      logic v, da, push, pop;
      logic [31:0] pc;
      v  = 1'($urandom_range(0, 1));
      da = 1'($urandom_range(0, 1));
      pc = 32'h1c000000 + 32'(i * 4);
      @(negedge clk);
      drive(v, pc, 1'b0, da, 1'b0);
      #1;
      chk("rnd_count", BUS_WD'(q_count), BUS_WD'(mq.size()));
      chk("rnd_le_depth", BUS_WD'(q_count <= 3'd4), BUS_WD'(1'b1));
      chk("rnd_allowin", BUS_WD'(qif.q_allowin), BUS_WD'(mq.size() != DEPTH));
      chk("rnd_valid", BUS_WD'(qif.q_to_ds_valid), BUS_WD'(mq.size() != 0));
      if (mq.size() != 0) chk("rnd_order", qif.q_to_ds_bus, mq[0]);
      push = v && (mq.size() != DEPTH);
      pop  = da && (mq.size() != 0);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(mk(pc, 1'b0));
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    mq.delete();

    // Test 6: async reset with 2 entries queued and ex_hold set
    drive(1'b1, 32'h1c000200, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h1c000204, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ar_pre_count", BUS_WD'(q_count), BUS_WD'(3'd2));
    chk("ar_pre_allowin", BUS_WD'(qif.q_allowin), BUS_WD'(1'b0));
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_valid", BUS_WD'(qif.q_to_ds_valid), BUS_WD'(1'b0));
    chk("ar_count", BUS_WD'(q_count), BUS_WD'(3'd0));
    chk("ar_bus",   qif.q_to_ds_bus, {BUS_WD{1'b0}});
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("ar_allowin", BUS_WD'(qif.q_allowin), BUS_WD'(1'b1));
    chk("ar_post_count", BUS_WD'(q_count), BUS_WD'(3'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fs_ds_inst_queue.md
Name: fs_ds_inst_queue

Overview:
- Decoupling instruction queue between the IF stage and the ID stage.
- Accepts the IF→ID bundle {esubcode, ecode, ex, inst, pc} with a valid/allowin handshake and buffers up to DEPTH entries.
- Presents the oldest entry to decode.
- Discards all contents on a pipeline flush: exception, ertn, or taken branch.
- Stops accepting entries after an entry marked as an exception, so nothing is fetched past a faulting PC.

Parameters:
- BUS_WD, 72, width of one IF→ID bundle (equals FS_TO_DS_BUS_WD).
- DEPTH, 4, number of entries; must be a power of two and ≥2.
- EX_BIT, 64, bit index of the fs_ex flag inside the bundle.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush (back_ex | back_ertn_flush | br_taken).
- fs_to_q_valid  in  1  IF presents a bundle.
- q_allowin  out  1  queue can accept a bundle this cycle.
- fs_to_q_bus  in  BUS_WD  bundle from IF.
- q_to_ds_valid  out  1  head entry is valid for decode.
- ds_allowin  in  1  decode consumes the head this cycle.
- q_to_ds_bus  out  BUS_WD  head entry.
- q_count  out  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- **Reset (resetn=0, asynchronous):**
  - Pointers, q_count and ex_hold clear to 0.
  - q_to_ds_valid=0.
  - q_to_ds_bus=0 (storage cleared).
  - q_allowin=1 once reset is released.
- **Storage:** DEPTH×BUS_WD register array, rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH. q_count is a separate counter (0..DEPTH) that distinguishes full from empty.
- **Push condition:** push = fs_to_q_valid & q_allowin & ~flush.
- **Pop condition:** pop = q_to_ds_valid & ds_allowin.
- **q_allowin** = (q_count != DEPTH) & ~ex_hold.
  - Depends only on registered state; there is no combinational path from ds_allowin.
  - When full, a simultaneous pop does not enable a push in the same cycle.
- **q_to_ds_valid** = (q_count != 0) & ~flush.
- **q_to_ds_bus** = mem[rd_ptr]. No bypass path: an entry pushed at edge N is visible to decode from cycle N+1 at the earliest, so first-word latency is 1 cycle.
- **Count update at each edge:**
  - push only: +1.
  - pop only: −1.
  - both: unchanged, both pointers advance.
  - neither: unchanged.
- **ex_hold:**
  - Set at the edge where a pushed bundle has bit EX_BIT=1.
  - Cleared only by flush or reset.
  - While set, q_allowin=0. Already-queued entries and the faulting entry still drain normally.
- **flush=1:**
  - At the next edge, rd_ptr=wr_ptr=0, q_count=0, ex_hold=0.
  - Any push in the flush cycle is dropped.
  - No pop occurs in the flush cycle because q_to_ds_valid is forced to 0.
  - Stored data is not cleared.
  - q_allowin returns to 1 in the following cycle.
- **Simultaneous flush and reset:** reset dominates.
- **Pointer wrap:** after pushing DEPTH entries and popping DEPTH entries, the pointers return to 0 and FIFO order is preserved.
- **Invariants:**
  - Data order is strictly FIFO.
  - An entry is never duplicated or lost except on flush.
  - q_to_ds_bus is stable while q_to_ds_valid=1 and ds_allowin=0.

Test Plan:
1. **Reset and basic FIFO order.** Release resetn. Push pc 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles with ds_allowin=0.
   - Required: q_count=3, q_allowin=1.
   - Then ds_allowin=1: pcs appear in order, one per cycle, and q_to_ds_valid drops after the third.
2. **Full / backpressure.** ds_allowin=0, push 4 entries.
   - Required: q_count=4, q_allowin=0.
   - A fifth fs_to_q_valid is held off. Pop plus push in the same full cycle yields q_count=3 next cycle and the push is not taken.
3. **Flush mid-stream.** Queue holds 3 entries; assert flush for one cycle together with fs_to_q_valid=1.
   - Required: q_to_ds_valid=0 in that cycle and q_count=0 next cycle.
   - The new push is dropped. A push at pc 0x1c000100 afterwards is the next output.
4. **Exception hold.** Push pc 0x1c000010 with bit64=1, then present 0x1c000014.
   - Required: q_allowin=0 from the next cycle, 0x1c000014 is never accepted, and 0x1c000010 still drains to decode.
   - A flush clears ex_hold and q_allowin=1 the following cycle.
5. **Wrap-around stress.** Run 1000 random push/pop cycles with ds_allowin toggling 50%, and compare against a reference queue model.
   - Required: no order mismatch, q_count matches the model, and q_count ≤4 always.
6. **Asynchronous reset mid-operation.** With 2 entries queued and ex_hold=1, drive resetn low between clock edges.
   - Required: q_to_ds_valid and q_count go to 0 immediately (before the next edge), and q_allowin=1 after release.
